aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES key-expansion unit that sits directly upstream of the AES encryption/decryption cores. It takes a cipher key and generates all Nr+1 round keys, one 32-bit word per clock, into internal storage. The cores then read any round key by index through a registered read port. Expansion runs once per new key, not once per block.

## Interface
- Nk, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
- Nr, default 10: number of rounds; legal values are 10, 12 and 14, and must equal Nk+6.
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to expand the key on `Key`.
- Key  input  [0:32*Nk-1]  cipher key; bit 0 is the MSB of byte 0 (FIPS-197 order).
- busy  output  1  high while expansion is in progress.
- key_valid  output  1  high when all round keys are stored and valid.
- rd_round  input  4  round index to read, 0..Nr.
- round_key  output  [0:127]  round key words w[4r]..w[4r+3], in the same bit order as `Key`.

## Operation
- States:
  - IDLE: after reset.
  - EXPAND: expansion in progress.
  - READY: all round keys stored.
- Storage: 4*(Nr+1) words, w[0..4Nr+3].
- `start` in IDLE or READY:
  - Key is captured into w[0..Nk-1] on that edge.
  - Word index i is set to Nk; state goes to EXPAND.
  - busy goes to 1 and key_valid to 0.
- `start` during EXPAND is ignored. The expansion in progress completes with the original key.
- Each EXPAND cycle writes exactly one word: w[i] = w[i-Nk] ^ temp, where temp is derived from w[i-1] as follows.
  - If i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}.
  - Else if Nk == 8 and i mod Nk == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- i mod Nk is tracked by a wrap counter (0..Nk-1); no divider is used.
- Rcon register:
  - Loaded with 8'h01 on start.
  - Advanced by xtime (x<<1, XOR 8'h1B when the MSB is set) after each use.
  - For Nk=4 it reaches 8'h36 at i=40.
- After writing w[4Nr+3], the state goes to READY: busy goes to 0 and key_valid to 1.
- Read port:
  - round_key is registered: `rd_round` sampled at edge n appears after edge n.
  - It is valid in any state and returns the current storage contents.
  - rd_round > Nr returns 128'h0.
- reset takes priority over start. It clears all storage, Rcon, i and round_key to 0, selects IDLE, and drives busy=0 and key_valid=0. Reset during EXPAND aborts the expansion and leaves no partial keys.

## Timing
- Reset values: busy=0, key_valid=0, round_key=0.
- Latency from the start edge to key_valid high is 4(Nr+1)-Nk EXPAND edges after the start edge:
  - AES-128: 40 edges.
  - AES-192: 46 edges.
  - AES-256: 52 edges.
- The combinational path per cycle is one SubWord (4 S-boxes), one XOR with Rcon and one 32-bit XOR.
- Round r's key is final once w[4r+3] has been written. Early-start consumers may rely on this.
- `start` on the same edge as key_valid rising (the last EXPAND cycle) is ignored.

## Configuration
- Macro: AES_KEY_SCHEDULE_ZEROIZE_EN.
- When defined, an extra input `zeroize` (1 bit) is added.
  - When zeroize is high at an edge, all storage and round_key are cleared and the state goes to IDLE with key_valid=0.
  - Priority: reset > zeroize > start.
- When undefined, the `zeroize` port is absent. Keys persist until reset or the next start.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box table/function and the xtime function;
  - the state enum (IDLE/EXPAND/READY);
  - the 32-bit word typedef;
  - the legal Nk/Nr constants, reused by the encryption and decryption cores.
- One sub-module, `aes_sub_word`: a combinational 4-byte S-box lookup.

## Test plan
- Key 000102030405060708090a0b0c0d0e0f, Nk=4, pulse start:
  - key_valid rises exactly 40 edges later;
  - rd_round=0 returns the key;
  - rd_round=10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- Key 2b7e151628aed2a6abf7158809cf4f3c:
  - rd_round=1 returns a0fafe1788542cb123a339392a6c7605;
  - rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- Nk=8, Nr=14, key 000102…1f:
  - key_valid rises after 52 edges;
  - rd_round=14 returns 24fc79ccbf0979e9371ac23c6d68de36.
- Start with key A, then pulse start with key B at cycle 10: B is ignored, and round 10 matches key A's expected value.
- Reset at cycle 20 of expansion:
  - the next cycle shows busy=0, key_valid=0;
  - every rd_round returns 0.
- rd_round=15 in READY: round_key is 0 one edge later. With the macro defined, zeroize in READY gives key_valid=0 and round 10 reads back as 0.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box and GF(2^8) helpers for the key schedule and cipher cores
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: key load, status and round-key read port between key schedule and cipher cores
interface aes_key_schedule_if #(parameter int NK = 4);
  logic              start;
  logic [0:32*NK-1]  key;
  logic              busy;
  logic              key_valid;
  logic [3:0]        rd_round;
  logic [0:127]      round_key;
  modport master (output start, key, rd_round, input busy, key_valid, round_key);
  modport slave (input start, key, rd_round, output busy, key_valid, round_key);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational 4-byte S-box substitution
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t a,
  output word_t y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES key expansion, one word per clock, registered round-key read port
// AES_KEY_SCHEDULE_ZEROIZE_EN adds a zeroize input that wipes all stored keys
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic clk,
  input  logic reset,
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_schedule_if.slave bus
);
  localparam int WORDS = 4 * (NR + 1);
  localparam int AW = $clog2(WORDS);
  logic clr;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  assign clr = reset | zeroize;
`else
  assign clr = reset;
`endif
  state_t state, state_n;
  word_t w [WORDS];
  logic [AW-1:0] i;
  logic [2:0] k;
  logic [7:0] rcon;
  word_t prev, sw_in, sw_out, temp;
  logic [5:0] base;
  logic take, last;
  assign take = bus.start && state != EXPAND;
  assign last = state == EXPAND && i == AW'(WORDS - 1);
  assign bus.busy = state == EXPAND;
  assign bus.key_valid = state == READY;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (clr) state_n = IDLE;
    else if (take) state_n = EXPAND;
    else if (last) state_n = READY;
  end
  // k tracks i mod NK; one S-box bank serves both the RotWord and the AES-256 mid-key step
  assign prev = w[i - AW'(1)];
  assign sw_in = k == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
  aes_sub_word u_sub (.a(sw_in), .y(sw_out));
  assign temp = k == 3'd0 ? sw_out ^ {rcon, 24'h0} : (NK == 8 && k == 3'd4) ? sw_out : prev;
  assign base = bus.rd_round > 4'(NR) ? 6'd0 : {bus.rd_round, 2'b00};
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < WORDS; j++) w[j] <= '0;
      i <= '0;
      k <= '0;
      rcon <= '0;
      bus.round_key <= '0;
    end else begin
      if (take) begin
        for (int j = 0; j < NK; j++) w[j] <= bus.key[32*j +: 32];
        i <= AW'(NK);
        k <= '0;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        w[i] <= w[i - AW'(NK)] ^ temp;
        i <= i + AW'(1);
        k <= k == 3'(NK - 1) ? 3'd0 : k + 3'd1;
        rcon <= k == 3'd0 ? xtime(rcon) : rcon;
      end
      bus.round_key <= bus.rd_round > 4'(NR) ? 128'h0 :
        {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed FIPS-197 vectors for AES-128 and AES-256 key expansion
module tb_aes_key_schedule;
  logic clk = 0;
  logic reset = 1;
  int errors = 0;
  int checks = 0;
  localparam logic [0:127] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] K1R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [0:127] K1R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [0:127] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] K2R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] K2R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:255] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] K3R1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] K3R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  aes_key_schedule_if #(.NK(4)) b4();
  aes_key_schedule_if #(.NK(8)) b8();
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  logic zeroize = 0;
  aes_key_schedule #(.NK(4), .NR(10)) dut4 (.clk(clk), .reset(reset), .zeroize(zeroize), .bus(b4));
  aes_key_schedule #(.NK(8), .NR(14)) dut8 (.clk(clk), .reset(reset), .zeroize(zeroize), .bus(b8));
`else
  aes_key_schedule #(.NK(4), .NR(10)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  aes_key_schedule #(.NK(8), .NR(14)) dut8 (.clk(clk), .reset(reset), .bus(b8));
`endif
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start4(input logic [0:127] k);
    b4.key = k;
    b4.start = 1;
    tick;
    b4.start = 0;
  endtask
  task automatic wait_valid4(output int n);
    n = 0;
    while (b4.key_valid !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
  endtask
  task automatic read4(input logic [3:0] r);
    b4.rd_round = r;
    tick;
  endtask
  task automatic test_reset;
    reset = 1;
    b4.start = 0; b8.start = 0;
    b4.key = '0; b8.key = '0;
    b4.rd_round = 0; b8.rd_round = 0;
    repeat (3) tick;
    checks++;
    if ({b4.busy, b4.key_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_flags4 busy/key_valid=%b expected 00", {b4.busy, b4.key_valid});
    end
    checks++;
    if (b4.round_key !== 128'h0) begin
      errors++; $display("FAIL reset_key4 got %h expected 0", b4.round_key);
    end
    checks++;
    if ({b8.busy, b8.key_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_flags8 busy/key_valid=%b expected 00", {b8.busy, b8.key_valid});
    end
    reset = 0;
    tick;
    checks++;
    if ({b4.busy, b4.key_valid, b4.round_key} !== 130'h0) begin
      errors++; $display("FAIL post_reset_idle busy/valid=%b key=%h expected all 0", {b4.busy, b4.key_valid}, b4.round_key);
    end
  endtask
  task automatic test_aes128;
    int n;
    start4(K1);
    checks++;
    if ({b4.busy, b4.key_valid} !== 2'b10) begin
      errors++; $display("FAIL start_busy busy/key_valid=%b expected 10", {b4.busy, b4.key_valid});
    end
    wait_valid4(n);
    checks++;
    if (n != 40) begin
      errors++; $display("FAIL latency128 got %0d edges expected 40", n);
    end
    checks++;
    if (b4.busy !== 1'b0) begin
      errors++; $display("FAIL ready_busy got %b expected 0", b4.busy);
    end
    read4(0);
    checks++;
    if (b4.round_key !== K1) begin
      errors++; $display("FAIL k1_round0 got %h expected %h", b4.round_key, K1);
    end
    read4(1);
    checks++;
    if (b4.round_key !== K1R1) begin
      errors++; $display("FAIL k1_round1 got %h expected %h", b4.round_key, K1R1);
    end
    read4(10);
    checks++;
    if (b4.round_key !== K1R10) begin
      errors++; $display("FAIL k1_round10 got %h expected %h", b4.round_key, K1R10);
    end
  endtask
  task automatic test_early_read;
    int n;
    start4(K2);
    b4.rd_round = 1;
    repeat (5) tick;
    checks++;
    if (b4.busy !== 1'b1 || b4.round_key !== K2R1) begin
      errors++; $display("FAIL early_round1 busy=%b got %h expected busy=1 %h", b4.busy, b4.round_key, K2R1);
    end
    wait_valid4(n);
    checks++;
    if (n != 35) begin
      errors++; $display("FAIL latency_rest got %0d edges expected 35", n);
    end
    read4(10);
    checks++;
    if (b4.round_key !== K2R10) begin
      errors++; $display("FAIL k2_round10 got %h expected %h", b4.round_key, K2R10);
    end
  endtask
  task automatic test_aes256;
    int n;
    b8.key = K3;
    b8.start = 1;
    tick;
    b8.start = 0;
    n = 0;
    while (b8.key_valid !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (n != 52) begin
      errors++; $display("FAIL latency256 got %0d edges expected 52", n);
    end
    b8.rd_round = 14;
    tick;
    checks++;
    if (b8.round_key !== K3R14) begin
      errors++; $display("FAIL k3_round14 got %h expected %h", b8.round_key, K3R14);
    end
    b8.rd_round = 1;
    tick;
    checks++;
    if (b8.round_key !== K3R1) begin
      errors++; $display("FAIL k3_round1 got %h expected %h", b8.round_key, K3R1);
    end
  endtask
  task automatic test_back_to_back;
    int n;
    start4(K1);
    repeat (9) tick;
    b4.key = K2;
    b4.start = 1;
    tick;
    b4.start = 0;
    wait_valid4(n);
    checks++;
    if (n + 10 != 40) begin
      errors++; $display("FAIL restart_latency got %0d edges expected 40", n + 10);
    end
    read4(10);
    checks++;
    if (b4.round_key !== K1R10) begin
      errors++; $display("FAIL ignored_start_round10 got %h expected %h", b4.round_key, K1R10);
    end
  endtask
  task automatic test_last_edge_start;
    start4(K2);
    repeat (39) tick;
    b4.key = K1;
    b4.start = 1;
    tick;
    b4.start = 0;
    checks++;
    if (b4.key_valid !== 1'b1) begin
      errors++; $display("FAIL last_edge_valid got %b expected 1", b4.key_valid);
    end
    tick;
    checks++;
    if ({b4.busy, b4.key_valid} !== 2'b01) begin
      errors++; $display("FAIL last_edge_hold busy/key_valid=%b expected 01", {b4.busy, b4.key_valid});
    end
    read4(10);
    checks++;
    if (b4.round_key !== K2R10) begin
      errors++; $display("FAIL last_edge_round10 got %h expected %h", b4.round_key, K2R10);
    end
  endtask
  task automatic test_reset_mid;
    start4(K2);
    repeat (19) tick;
    reset = 1;
    tick;
    reset = 0;
    checks++;
    if ({b4.busy, b4.key_valid, b4.round_key} !== 130'h0) begin
      errors++; $display("FAIL abort_state busy/valid=%b key=%h expected all 0", {b4.busy, b4.key_valid}, b4.round_key);
    end
    for (int r = 0; r <= 10; r++) begin
      read4(4'(r));
      checks++;
      if (b4.round_key !== 128'h0) begin
        errors++; $display("FAIL abort_round%0d got %h expected 0", r, b4.round_key);
      end
    end
    checks++;
    if ({b4.busy, b4.key_valid} !== 2'b00) begin
      errors++; $display("FAIL abort_idle busy/key_valid=%b expected 00", {b4.busy, b4.key_valid});
    end
  endtask
  task automatic test_out_of_range;
    int n;
    start4(K1);
    wait_valid4(n);
    read4(10);
    checks++;
    if (b4.round_key !== K1R10) begin
      errors++; $display("FAIL oor_base got %h expected %h", b4.round_key, K1R10);
    end
    read4(15);
    checks++;
    if (b4.round_key !== 128'h0) begin
      errors++; $display("FAIL oor_round15 got %h expected 0", b4.round_key);
    end
    read4(11);
    checks++;
    if (b4.round_key !== 128'h0) begin
      errors++; $display("FAIL oor_round11 got %h expected 0", b4.round_key);
    end
  endtask
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  task automatic test_zeroize;
    zeroize = 1;
    tick;
    zeroize = 0;
    checks++;
    if (b4.key_valid !== 1'b0) begin
      errors++; $display("FAIL zeroize_valid got %b expected 0", b4.key_valid);
    end
    read4(10);
    checks++;
    if (b4.round_key !== 128'h0) begin
      errors++; $display("FAIL zeroize_round10 got %h expected 0", b4.round_key);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_aes128;
    test_early_read;
    test_aes256;
    test_back_to_back;
    test_last_edge_start;
    test_reset_mid;
    test_out_of_range;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    test_zeroize;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
